ascon_stream_ctrl: RTL and testbench
====================================

// Module: ascon_stream_ctrl
// PURPOSE
//  Host-side sequencer for the ASCON-128 core. Accepts an encryption request, then streams
//  1 associated-data block and NB_PT plaintext blocks into the core with timed data_valid pulses.
//  Buffers the returned cipher blocks and the final tag behind valid/ready outputs.
//  Sits between the host bus adapter and the core FSM/datapath; key/nonce loading is out of scope.
// PARAMETERS
//  DW          64  data block width
//  NB_PT       3   plaintext blocks per message (1..4)
//  INIT_CYC    16  cycles from core_start_o to first data pulse (init permutation + margins)
//  GAP_CYC     16  minimum cycles between consecutive core_data_valid_o pulses
//  TAG_TO      32  cycles allowed from last data pulse to core_end_i before timeout
// PORTS
//  clock_i          in   1    clock
//  resetb_i         in   1    asynchronous, active-low reset
//  req_valid_i      in   1    host requests a new message
//  req_ready_o      out  1    controller idle, request accepted when both high
//  in_valid_i       in   1    input block available
//  in_ready_o       out  1    controller takes in_data_i when both high
//  in_data_i        in   DW   AD block first, then plaintext blocks in order
//  core_start_o     out  1    one-cycle start pulse to core
//  core_data_valid_o out 1    one-cycle data pulse to core
//  core_data_o      out  DW   block presented to core, held stable between pulses
//  core_cipher_valid_i in 1   core cipher block strobe
//  core_cipher_i    in   DW   cipher block from core
//  core_end_i       in   1    core end-of-message strobe
//  core_tag_i       in   128  tag, valid with core_end_i
//  out_valid_o/out_ready_i  out/in 1  cipher stream handshake
//  out_data_o       out  DW   cipher block
//  out_last_o       out  1    high on block NB_PT-1
//  tag_valid_o/tag_ready_i  out/in 1  tag handshake
//  tag_o            out  128  captured tag
//  busy_o           out  1    state != S_IDLE
//  err_o            out  1    sticky: FIFO overflow or tag timeout; cleared on next accepted request
// BEHAVIOUR
//  Reset: state S_IDLE; req_ready_o=1; all other outputs 0; counters, FIFO, tag reg cleared.
//  States/transitions:
//   S_IDLE:  req_valid_i -> S_START (req_ready_o=1 only here, with tag/FIFO empty)
//   S_START: core_start_o=1 one cycle; load gap cnt=INIT_CYC -> S_WAIT
//   S_WAIT:  decrement gap cnt; at 0 -> S_FETCH, or S_WTAG once blk cnt==NB_PT+1
//   S_FETCH: in_ready_o=1 (PT blocks additionally need >=1 free FIFO slot); on handshake latch
//            core_data_o -> S_PULSE
//   S_PULSE: core_data_valid_o=1 one cycle; blk cnt++; gap cnt=GAP_CYC -> S_WAIT
//   S_WTAG:  timeout cnt from TAG_TO; core_end_i -> capture tag, tag_valid_o=1 -> S_DRAIN;
//            timeout -> err_o=1, -> S_IDLE (no tag)
//   S_DRAIN: wait tag handshake and FIFO empty -> S_IDLE
//  Pulse count per message: exactly 1+NB_PT data pulses; block 0 is AD, never enters FIFO.
//  core_cipher_valid_i pushes core_cipher_i into 2-entry FIFO in any state except S_IDLE;
//   push while full: block dropped, err_o=1. Simultaneous push and pop when full: legal, no error.
//  out_last_o asserted with the NB_PT-th popped block (pop cnt wraps to 0 after it).
//  core_end_i in a state other than S_WTAG: ignored (no tag capture), err_o=1.
//  Latency: req handshake -> core_start_o next cycle; first data pulse >= INIT_CYC+2 cycles later.
//  Tag held until tag_ready_i; tag_valid_o drops the cycle after handshake.
//  Reset mid-message: immediate return to reset values; no partial outputs retained.
// STRUCTURE
//  ascon_pack: ctrl_state_t enum, CTRL_INIT_CYC/CTRL_GAP_CYC/CTRL_TAG_TO defaults.
//  Sub-module ascon_out_fifo (DW x2, push/pop/full/empty/count); counters and FSM in top.
// TESTING
//  Nominal: req, AD=0x0011..77, PT blocks P0..P2 -> 4 pulses, gaps>=16, 3 cipher out, last on 3rd, tag out.
//  Backpressure: out_ready_i=0 throughout -> 2 blocks buffered, 3rd in_ready_o held 0, no err_o.
//  Tag timeout: core never raises core_end_i -> err_o=1 at TAG_TO+1, back to S_IDLE, req_ready_o=1.
//  Overflow: inject 3 core_cipher_valid_i with out_ready_i=0 -> 3rd dropped, err_o=1; next req clears it.
//  Reset mid-PT (after 2nd pulse): all outputs 0, req_ready_o=1; following message completes cleanly.
//  Host stall: in_valid_i low 50 cycles in S_FETCH -> no pulse issued, core_data_o stable.

Source files
------------

// File: rtl/ascon_stream_ctrl_pkg.sv
// ascon_stream_ctrl_pkg: shared FSM state type, default timing constants and counter sizing helper
//   ctrl_state_t   sequencer states
//   CTRL_*         default parameter values for ascon_stream_ctrl
//   cnt_w()        bits needed to hold 0..max_val
package ascon_stream_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_FETCH,
        S_PULSE,
        S_WTAG,
        S_DRAIN
    } ctrl_state_t;
    localparam int CTRL_DW       = 64;
    localparam int CTRL_NB_PT    = 3;
    localparam int CTRL_INIT_CYC = 16;
    localparam int CTRL_GAP_CYC  = 16;
    localparam int CTRL_TAG_TO   = 32;
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/ascon_stream_ctrl_out_fifo.sv
// ascon_stream_ctrl_out_fifo: two-entry cipher block FIFO
//   clock_i, resetb_i   clock, asynchronous active-low reset
//   push_i, data_i      write strobe and block (ignored when full unless popping)
//   pop_i, data_o       read strobe and head block (zero when empty after reset)
//   full_o, empty_o     occupancy flags
//   count_o             number of stored blocks (0..2)
module ascon_stream_ctrl_out_fifo #(
    parameter int DW = 64
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [1:0]    count_o
);
    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full_o  = count_o == 2'd2;
    assign empty_o = count_o == 2'd0;
    // a push into a full FIFO still lands when the head leaves in the same cycle
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_o <= 2'd0;
        end else begin
            if (wr_en)
                mem[wr_ptr] <= data_i;
            wr_ptr  <= wr_en ? ~wr_ptr : wr_ptr;
            rd_ptr  <= rd_en ? ~rd_ptr : rd_ptr;
            count_o <= count_o + 2'(wr_en) - 2'(rd_en);
        end
    end
endmodule

// File: rtl/ascon_stream_ctrl.sv
// ascon_stream_ctrl: host-side sequencer streaming one AD block and NB_PT plaintext blocks into the ASCON-128 core
//   clock_i, resetb_i                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o          message request handshake (ready only when idle and drained)
//   in_valid_i / in_ready_o / in_data_i  AD block then plaintext blocks from the host
//   core_start_o, core_data_valid_o    one-cycle strobes to the core
//   core_data_o                        block presented to the core, held between pulses
//   core_cipher_valid_i, core_cipher_i cipher block strobe from the core
//   core_end_i, core_tag_i             end-of-message strobe and tag from the core
//   out_valid_o / out_ready_i / out_data_o / out_last_o  buffered cipher stream
//   tag_valid_o / tag_ready_i / tag_o  captured tag
//   busy_o                             not idle
//   err_o                              sticky overflow / timeout / stray end, cleared on next accepted request
module ascon_stream_ctrl
    import ascon_stream_ctrl_pkg::*;
#(
    parameter int DW       = CTRL_DW,
    parameter int NB_PT    = CTRL_NB_PT,
    parameter int INIT_CYC = CTRL_INIT_CYC,
    parameter int GAP_CYC  = CTRL_GAP_CYC,
    parameter int TAG_TO   = CTRL_TAG_TO
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          core_start_o,
    output logic          core_data_valid_o,
    output logic [DW-1:0] core_data_o,
    input  logic          core_cipher_valid_i,
    input  logic [DW-1:0] core_cipher_i,
    input  logic          core_end_i,
    input  logic [127:0]  core_tag_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          tag_valid_o,
    input  logic          tag_ready_i,
    output logic [127:0]  tag_o,
    output logic          busy_o,
    output logic          err_o
);
    localparam int GMAX = (INIT_CYC > GAP_CYC) ? INIT_CYC : GAP_CYC;
    localparam int GW   = cnt_w(GMAX);
    localparam int TW   = cnt_w(TAG_TO);
    localparam int BW   = cnt_w(NB_PT + 1);
    localparam int PW   = cnt_w(NB_PT);

    ctrl_state_t   state;
    ctrl_state_t   state_nx;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] to_cnt;
    logic [BW-1:0] blk_cnt;
    logic [PW-1:0] pop_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    fifo_count;
    logic          push;
    logic          pop;
    logic          req_hs;
    logic          in_hs;
    logic          got_end;
    logic          timeout;
    logic          ovf;
    logic          stray_end;

    assign push        = core_cipher_valid_i && state != S_IDLE;
    assign pop         = out_valid_o && out_ready_i;
    assign out_valid_o = !fifo_empty;
    assign out_last_o  = out_valid_o && pop_cnt == PW'(NB_PT - 1);
    assign busy_o      = state != S_IDLE;
    assign req_hs      = req_valid_i && req_ready_o;
    assign in_hs       = in_valid_i && in_ready_o;
    assign got_end     = state == S_WTAG && core_end_i;
    assign timeout     = state == S_WTAG && !core_end_i && to_cnt == '0;
    assign ovf         = push && fifo_full && !pop;
    assign stray_end   = core_end_i && state != S_WTAG;

    ascon_stream_ctrl_out_fifo #(.DW(DW)) u_fifo (
        .clock_i (clock_i),
        .resetb_i(resetb_i),
        .push_i  (push),
        .data_i  (core_cipher_i),
        .pop_i   (pop),
        .data_o  (out_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx          = state;
        req_ready_o       = 1'b0;
        in_ready_o        = 1'b0;
        core_start_o      = 1'b0;
        core_data_valid_o = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready_o = fifo_empty && !tag_valid_o;
                state_nx    = (req_valid_i && req_ready_o) ? S_START : S_IDLE;
            end
            S_START: begin
                core_start_o = 1'b1;
                state_nx     = S_WAIT;
            end
            S_WAIT:
                state_nx = (gap_cnt != '0) ? S_WAIT : (blk_cnt == BW'(NB_PT + 1)) ? S_WTAG : S_FETCH;
            S_FETCH: begin
                // the AD block produces no cipher, so only plaintext blocks need room downstream
                in_ready_o = blk_cnt == '0 || fifo_count != 2'd2;
                state_nx   = (in_valid_i && in_ready_o) ? S_PULSE : S_FETCH;
            end
            S_PULSE: begin
                core_data_valid_o = 1'b1;
                state_nx          = S_WAIT;
            end
            S_WTAG:
                state_nx = got_end ? S_DRAIN : timeout ? S_IDLE : S_WTAG;
            S_DRAIN:
                state_nx = (!tag_valid_o && fifo_empty) ? S_IDLE : S_DRAIN;
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            gap_cnt     <= '0;
            to_cnt      <= '0;
            blk_cnt     <= '0;
            pop_cnt     <= '0;
            core_data_o <= '0;
            tag_valid_o <= 1'b0;
            tag_o       <= '0;
            err_o       <= 1'b0;
        end else begin
            gap_cnt     <= (state == S_START) ? GW'(INIT_CYC) :
                           (state == S_PULSE) ? GW'(GAP_CYC) :
                           (state == S_WAIT && gap_cnt != '0) ? gap_cnt - GW'(1) : gap_cnt;
            // runs from every data pulse, so core_end_i is honoured for TAG_TO cycles after the last one
            to_cnt      <= (state == S_PULSE) ? TW'(TAG_TO - 1) :
                           ((state == S_WAIT || state == S_WTAG) && to_cnt != '0) ? to_cnt - TW'(1) : to_cnt;
            blk_cnt     <= (state == S_START) ? '0 : (state == S_PULSE) ? blk_cnt + BW'(1) : blk_cnt;
            pop_cnt     <= req_hs ? '0 : !pop ? pop_cnt : out_last_o ? '0 : pop_cnt + PW'(1);
            core_data_o <= in_hs ? in_data_i : core_data_o;
            tag_valid_o <= got_end || (tag_valid_o && !tag_ready_i);
            tag_o       <= got_end ? core_tag_i : tag_o;
            err_o       <= req_hs ? 1'b0 : (err_o || ovf || timeout || stray_end);
        end
    end
endmodule

// File: tb/tb_ascon_stream_ctrl.sv
// tb_ascon_stream_ctrl: directed self-checking bench for ascon_stream_ctrl with a small core/host stub
module tb_ascon_stream_ctrl;
    import ascon_stream_ctrl_pkg::*;
    localparam int NB = CTRL_NB_PT;
    localparam logic [63:0]  KEY = 64'h5a5a_0f0f_3c3c_9696;
    localparam logic [127:0] TAG = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    logic         clock_i;
    logic         resetb_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [63:0]  in_data_i;
    logic         core_start_o;
    logic         core_data_valid_o;
    logic [63:0]  core_data_o;
    logic         core_cipher_valid_i;
    logic [63:0]  core_cipher_i;
    logic         core_end_i;
    logic [127:0] core_tag_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [63:0]  out_data_o;
    logic         out_last_o;
    logic         tag_valid_o;
    logic         tag_ready_i;
    logic [127:0] tag_o;
    logic         busy_o;
    logic         err_o;

    int tests;
    int fails;
    int cyc;
    int hidx;
    int start_cyc;
    bit host_en;
    bit end_en;
    logic        mdl_cv;
    logic        mdl_end;
    logic        inj_v;
    logic [63:0] mdl_cd;
    logic [63:0] inj_d;
    logic [63:0] blocks [4];
    int          pulse_cyc [$];
    logic [63:0] pulse_dat [$];
    logic [63:0] out_dat [$];
    logic        out_lst [$];

    assign core_cipher_valid_i = mdl_cv | inj_v;
    assign core_cipher_i       = inj_v ? inj_d : mdl_cd;
    assign core_end_i          = mdl_end;
    assign core_tag_i          = TAG;

    ascon_stream_ctrl dut (
        .clock_i            (clock_i),
        .resetb_i           (resetb_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .in_data_i          (in_data_i),
        .core_start_o       (core_start_o),
        .core_data_valid_o  (core_data_valid_o),
        .core_data_o        (core_data_o),
        .core_cipher_valid_i(core_cipher_valid_i),
        .core_cipher_i      (core_cipher_i),
        .core_end_i         (core_end_i),
        .core_tag_i         (core_tag_i),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_data_o         (out_data_o),
        .out_last_o         (out_last_o),
        .tag_valid_o        (tag_valid_o),
        .tag_ready_i        (tag_ready_i),
        .tag_o              (tag_o),
        .busy_o             (busy_o),
        .err_o              (err_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc <= cyc + 1;

    // core stub: cipher = block ^ KEY three cycles after each PT pulse, end 25 cycles after the last pulse
    initial begin
        int mblk;
        int cdly;
        int edly;
        mdl_cv = 1'b0; mdl_end = 1'b0; mdl_cd = '0;
        mblk = 0; cdly = 0; edly = 0;
        forever begin
            @(posedge clock_i); #1;
            mdl_cv = 1'b0;
            mdl_end = 1'b0;
            if (cdly > 0) begin cdly--; if (cdly == 0) mdl_cv = 1'b1; end
            if (edly > 0) begin edly--; if (edly == 0) mdl_end = end_en; end
            if (!resetb_i) begin mblk = 0; cdly = 0; edly = 0; mdl_cv = 1'b0; mdl_end = 1'b0; end
            if (core_start_o) mblk = 0;
            if (core_data_valid_o) begin
                if (mblk > 0) begin mdl_cd = core_data_o ^ KEY; cdly = 3; end
                mblk++;
                if (mblk == NB + 1) edly = 25;
            end
        end
    end

    // host stub: presents blocks[hidx] while enabled, advances on handshake
    initial begin
        bit hs;
        in_valid_i = 1'b0; in_data_i = '0;
        forever begin
            @(negedge clock_i);
            hs = in_valid_i && in_ready_o;
            @(posedge clock_i); #1;
            if (hs) hidx++;
            in_valid_i = host_en && hidx <= NB;
            in_data_i  = blocks[(hidx > NB) ? NB : hidx];
        end
    end

    always @(negedge clock_i) begin
        if (core_data_valid_o) begin pulse_cyc.push_back(cyc); pulse_dat.push_back(core_data_o); end
        if (core_start_o) start_cyc = cyc;
        if (out_valid_o && out_ready_i) begin out_dat.push_back(out_data_o); out_lst.push_back(out_last_o); end
    end

    task automatic tick();
        @(posedge clock_i); #1;
    endtask

    task automatic clear_logs();
        pulse_cyc.delete(); pulse_dat.delete(); out_dat.delete(); out_lst.delete();
    endtask

    task automatic start_msg(output bit ok);
        ok = 1'b0;
        req_valid_i = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock_i);
            ok = req_ready_o;
            tick();
        end
        req_valid_i = 1'b0;
    endtask

    task automatic wait_tag(input int budget, output bit ok);
        for (int i = 0; i < budget && !tag_valid_o; i++) tick();
        ok = tag_valid_o;
    endtask

    task automatic take_tag_and_idle(output bit ok);
        tag_ready_i = 1'b1;
        tick();
        tag_ready_i = 1'b0;
        for (int i = 0; i < 50 && busy_o; i++) tick();
        ok = !busy_o;
    endtask

    task automatic test_reset();
        resetb_i = 1'b0;
        repeat (3) tick();
        tests++;
        if ({req_ready_o, busy_o, core_start_o, core_data_valid_o, in_ready_o, out_valid_o, out_last_o, tag_valid_o, err_o} !== 9'b1_0000_0000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 100000000", {req_ready_o, busy_o, core_start_o, core_data_valid_o, in_ready_o, out_valid_o, out_last_o, tag_valid_o, err_o});
        end
        tests++;
        if ({core_data_o, out_data_o, tag_o} !== '0) begin
            fails++; $display("FAIL reset_data: got %h expected 0", {core_data_o, out_data_o, tag_o});
        end
        resetb_i = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        bit ok;
        int gmin;
        clear_logs(); hidx = 0; host_en = 1; end_en = 1; out_ready_i = 1'b1;
        start_msg(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL nom_req_accept: got %b expected 1", ok); end
        tests++; if (core_start_o !== 1'b1) begin fails++; $display("FAIL nom_start_pulse: got %b expected 1", core_start_o); end
        tick();
        tests++; if (core_start_o !== 1'b0) begin fails++; $display("FAIL nom_start_one_cycle: got %b expected 0", core_start_o); end
        wait_tag(400, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL nom_tag_wait: got %b expected 1", ok); end
        tests++; if (pulse_dat.size() != NB + 1) begin fails++; $display("FAIL nom_pulse_count: got %0d expected %0d", pulse_dat.size(), NB + 1); end
        for (int i = 0; i < pulse_dat.size() && i <= NB; i++) begin
            tests++;
            if (pulse_dat[i] !== blocks[i]) begin fails++; $display("FAIL nom_pulse_data[%0d]: got %h expected %h", i, pulse_dat[i], blocks[i]); end
        end
        if (pulse_cyc.size() > 0) begin
            tests++;
            if (pulse_cyc[0] - start_cyc < CTRL_INIT_CYC + 2) begin fails++; $display("FAIL nom_init_delay: got %0d expected >= %0d", pulse_cyc[0] - start_cyc, CTRL_INIT_CYC + 2); end
        end
        gmin = 1000;
        for (int i = 1; i < pulse_cyc.size(); i++) if (pulse_cyc[i] - pulse_cyc[i-1] < gmin) gmin = pulse_cyc[i] - pulse_cyc[i-1];
        tests++; if (gmin < CTRL_GAP_CYC) begin fails++; $display("FAIL nom_min_gap: got %0d expected >= %0d", gmin, CTRL_GAP_CYC); end
        tests++; if (out_dat.size() != NB) begin fails++; $display("FAIL nom_cipher_count: got %0d expected %0d", out_dat.size(), NB); end
        for (int i = 0; i < out_dat.size() && i < NB; i++) begin
            tests++;
            if ({out_lst[i], out_dat[i]} !== {1'(i == NB - 1), blocks[i+1] ^ KEY}) begin
                fails++; $display("FAIL nom_cipher[%0d]: got last=%b %h expected last=%b %h", i, out_lst[i], out_dat[i], i == NB - 1, blocks[i+1] ^ KEY);
            end
        end
        tests++; if (tag_o !== TAG) begin fails++; $display("FAIL nom_tag: got %h expected %h", tag_o, TAG); end
        take_tag_and_idle(ok);
        tests++; if ({ok, tag_valid_o, req_ready_o, err_o} !== 4'b1010) begin fails++; $display("FAIL nom_end_state: got %b expected 1010", {ok, tag_valid_o, req_ready_o, err_o}); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        clear_logs(); hidx = 0; host_en = 1; end_en = 1; out_ready_i = 1'b0;
        start_msg(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL bp_req_accept: got %b expected 1", ok); end
        repeat (120) tick();
        tests++; if (pulse_dat.size() != 3) begin fails++; $display("FAIL bp_pulses_stalled: got %0d expected 3", pulse_dat.size()); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin if (in_ready_o !== 1'b0) bad++; tick(); end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_in_ready_held: got %0d high cycles expected 0", bad); end
        tests++;
        if ({out_valid_o, err_o, busy_o, out_data_o} !== {3'b101, blocks[1] ^ KEY}) begin
            fails++; $display("FAIL bp_buffered: got v=%b e=%b b=%b %h expected 1 0 1 %h", out_valid_o, err_o, busy_o, out_data_o, blocks[1] ^ KEY);
        end
        out_ready_i = 1'b1;
        wait_tag(300, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL bp_tag_wait: got %b expected 1", ok); end
        tests++;
        if (out_dat.size() != NB || out_dat[NB-1] !== (blocks[NB] ^ KEY) || out_lst[NB-1] !== 1'b1) begin
            fails++; $display("FAIL bp_drain: got %0d blocks expected %0d ending %h", out_dat.size(), NB, blocks[NB] ^ KEY);
        end
        take_tag_and_idle(ok);
        tests++; if ({ok, err_o} !== 2'b10) begin fails++; $display("FAIL bp_end_state: got %b expected 10", {ok, err_o}); end
    endtask

    task automatic test_host_stall();
        bit ok;
        int bad;
        logic [63:0] d0;
        clear_logs(); hidx = 0; host_en = 0; end_en = 1; out_ready_i = 1'b1;
        start_msg(ok);
        for (int i = 0; i < 40 && !in_ready_o; i++) tick();
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL stall_fetch_reached: got %b expected 1", in_ready_o); end
        d0 = core_data_o;
        bad = 0;
        for (int i = 0; i < 50; i++) begin if (core_data_o !== d0 || in_ready_o !== 1'b1) bad++; tick(); end
        tests++; if (bad != 0 || pulse_dat.size() != 0) begin fails++; $display("FAIL stall_hold: got %0d changes %0d pulses expected 0 0", bad, pulse_dat.size()); end
        host_en = 1;
        wait_tag(400, ok);
        tests++; if (ok !== 1'b1 || pulse_dat.size() != NB + 1) begin fails++; $display("FAIL stall_resume: got tag=%b pulses=%0d expected 1 %0d", ok, pulse_dat.size(), NB + 1); end
        take_tag_and_idle(ok);
    endtask

    task automatic test_timeout();
        bit ok;
        int ecyc;
        clear_logs(); hidx = 0; host_en = 1; end_en = 0; out_ready_i = 1'b1;
        start_msg(ok);
        for (int i = 0; i < 300 && !err_o; i++) tick();
        ok = err_o; ecyc = cyc;
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL to_err: got %b expected 1", ok); end
        if (pulse_cyc.size() == NB + 1) begin
            tests++;
            if (ecyc - pulse_cyc[NB] != CTRL_TAG_TO + 1) begin fails++; $display("FAIL to_delay: got %0d expected %0d", ecyc - pulse_cyc[NB], CTRL_TAG_TO + 1); end
        end else begin
            tests++; fails++; $display("FAIL to_pulse_count: got %0d expected %0d", pulse_cyc.size(), NB + 1);
        end
        tests++; if ({busy_o, req_ready_o, tag_valid_o} !== 3'b010) begin fails++; $display("FAIL to_idle: got %b expected 010", {busy_o, req_ready_o, tag_valid_o}); end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_logs(); hidx = 0; host_en = 1; end_en = 1; out_ready_i = 1'b0;
        start_msg(ok);
        tests++; if ({ok, err_o} !== 2'b10) begin fails++; $display("FAIL ovf_req_clears_prior: got %b expected 10", {ok, err_o}); end
        tick();
        for (int i = 0; i < 3; i++) begin inj_v = 1'b1; inj_d = 64'hC0DE_0000_0000_0000 + 64'(i); tick(); end
        inj_v = 1'b0;
        tests++;
        if ({err_o, out_valid_o, out_data_o} !== {2'b11, 64'hC0DE_0000_0000_0000}) begin
            fails++; $display("FAIL ovf_flag: got e=%b v=%b %h expected 1 1 c0de000000000000", err_o, out_valid_o, out_data_o);
        end
        repeat (5) tick();
        out_ready_i = 1'b1;
        wait_tag(400, ok);
        tests++;
        if (!ok || out_dat.size() != NB + 2 || out_dat[0] !== 64'hC0DE_0000_0000_0000 || out_dat[1] !== 64'hC0DE_0000_0000_0001 || out_dat[2] !== (blocks[1] ^ KEY)) begin
            fails++; $display("FAIL ovf_drop: got tag=%b %0d blocks expected 1 %0d (third injected dropped)", ok, out_dat.size(), NB + 2);
        end
        take_tag_and_idle(ok);
        tests++; if ({ok, err_o} !== 2'b11) begin fails++; $display("FAIL ovf_sticky: got %b expected 11", {ok, err_o}); end
        clear_logs(); hidx = 0;
        start_msg(ok);
        tests++; if ({ok, err_o} !== 2'b10) begin fails++; $display("FAIL ovf_clear_on_req: got %b expected 10", {ok, err_o}); end
        wait_tag(400, ok);
        tests++;
        if (!ok || out_lst.size() != NB || {out_lst[0], out_lst[1], out_lst[2]} !== 3'b001) begin
            fails++; $display("FAIL ovf_next_msg_last: got tag=%b %0d blocks expected 1 %0d last on final", ok, out_lst.size(), NB);
        end
        take_tag_and_idle(ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs(); hidx = 0; host_en = 1; end_en = 1; out_ready_i = 1'b1;
        start_msg(ok);
        for (int i = 0; i < 200 && pulse_dat.size() < 2; i++) tick();
        repeat (10) tick();
        host_en = 0;
        resetb_i = 1'b0;
        #1;
        tests++;
        if ({req_ready_o, busy_o, core_start_o, core_data_valid_o, in_ready_o, out_valid_o, out_last_o, tag_valid_o, err_o} !== 9'b1_0000_0000 || core_data_o !== '0) begin
            fails++; $display("FAIL rst_mid_outputs: got %b data %h expected 100000000 data 0", {req_ready_o, busy_o, core_start_o, core_data_valid_o, in_ready_o, out_valid_o, out_last_o, tag_valid_o, err_o}, core_data_o);
        end
        tick(); tick();
        resetb_i = 1'b1;
        tick();
        clear_logs(); hidx = 0; host_en = 1;
        start_msg(ok);
        wait_tag(400, ok);
        tests++;
        if (!ok || pulse_dat.size() != NB + 1 || out_dat.size() != NB || out_lst[NB-1] !== 1'b1 || out_dat[0] !== (blocks[1] ^ KEY)) begin
            fails++; $display("FAIL rst_mid_next_msg: got tag=%b pulses=%0d blocks=%0d expected 1 %0d %0d", ok, pulse_dat.size(), out_dat.size(), NB + 1, NB);
        end
        take_tag_and_idle(ok);
        tests++; if ({ok, err_o, tag_o} !== {2'b10, TAG}) begin fails++; $display("FAIL rst_mid_clean_end: got %b %h expected 10 %h", {ok, err_o}, tag_o, TAG); end
    endtask

    initial begin
        tests = 0; fails = 0; hidx = 0; host_en = 0; end_en = 1;
        req_valid_i = 1'b0; out_ready_i = 1'b0; tag_ready_i = 1'b0; inj_v = 1'b0; inj_d = '0;
        blocks[0] = 64'h0011_2233_4455_6677;
        blocks[1] = 64'h1111_0000_aaaa_0001;
        blocks[2] = 64'h2222_0000_bbbb_0002;
        blocks[3] = 64'h3333_0000_cccc_0003;
        test_reset();
        test_nominal();
        test_backpressure();
        test_host_stall();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
